// File: rtl/perf_tx_pkg.sv
// Shared types and frame constants for the performance-counter UART reporter.
package perf_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } perf_tx_state_e;

   localparam logic [7:0] PERF_TX_HEADER     = 8'hA5;
   localparam int         PERF_TX_DATA_BYTES = 16;

   // Header plus four 32-bit counters; the checksum build adds one trailing byte.
   localparam int PERF_TX_FRAME_BYTES      = 1 + PERF_TX_DATA_BYTES;
   localparam int PERF_TX_FRAME_BYTES_CSUM = PERF_TX_FRAME_BYTES + 1;

endpackage

// File: rtl/perf_count_uart_tx_uart_tx_byte.sv
// Byte-level 8N1 serializer: baud down-counter plus shift register.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | line high, waiting for start
// ST_START | driving the start bit (0)
// ST_DATA  | driving data bits, LSB first
// ST_STOP  | driving the stop bit (1); done pulses on its last cycle
//
// done is combinational so the byte sequencer can chain the next byte on the
// same edge that ends the stop bit, leaving no idle gap between bytes.
module uart_tx_byte #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clk_en,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       done
);
   import perf_tx_pkg::*;

   localparam int             BW        = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0]  BAUD_LOAD = BW'(CLKS_PER_BIT - 1);

   perf_tx_state_e  state_q, state_d;
   logic [BW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d;
   logic            bit_end;

   assign bit_end = clk_en && (baud_q == '0);
   assign done    = bit_end && (state_q == ST_STOP);
   assign tx      = tx_q;

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   // Next-state, baud timing and line value; everything holds while clk_en is low.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      if (clk_en) begin
         if (state_q != ST_IDLE && !bit_end) begin
            baud_d = baud_q - 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d = ST_START;
                  tx_d    = 1'b0;
                  shift_d = data;
                  baud_d  = BAUD_LOAD;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  state_d = ST_DATA;
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
                  bit_d   = 3'd7;
                  baud_d  = BAUD_LOAD;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  baud_d = BAUD_LOAD;
                  if (bit_q == 3'd0) begin
                     state_d = ST_STOP;
                     tx_d    = 1'b1;
                  end else begin
                     bit_d   = bit_q - 1'b1;
                     tx_d    = shift_q[0];
                     shift_d = shift_q >> 1;
                  end
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  if (start) begin
                     state_d = ST_START;
                     tx_d    = 1'b0;
                     shift_d = data;
                     baud_d  = BAUD_LOAD;
                  end else begin
                     state_d = ST_IDLE;
                     tx_d    = 1'b1;
                     baud_d  = '0;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/perf_count_uart_tx.sv
// Snapshots the four core performance counters on send and streams them as an
// 8N1 frame: header 0xA5, then 16 counter bytes (MSB byte of each word first).
// Build option PERF_TX_CHECKSUM_EN appends the XOR of the 16 data bytes.
module perf_count_uart_tx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_en,
   input  logic [31:0] cycle_count,
   input  logic [31:0] instr_count,
   input  logic [31:0] load_stall_count,
   input  logic [31:0] branch_stall_count,
   input  logic        send,
   output logic        tx,
   output logic        busy,
   output logic        frame_done
);
   import perf_tx_pkg::*;

`ifdef PERF_TX_CHECKSUM_EN
   localparam int FRAME_BYTES = PERF_TX_FRAME_BYTES_CSUM;
`else
   localparam int FRAME_BYTES = PERF_TX_FRAME_BYTES;
`endif
   localparam logic [4:0] LAST_IDX = 5'(FRAME_BYTES - 1);

   logic [127:0] shadow_q, shadow_d;
   logic [4:0]   byte_idx_q, byte_idx_d;
   logic         busy_q, busy_d;
   logic         frame_done_q, frame_done_d;
   logic         accept;
   logic         byte_start;
   logic [7:0]   byte_data;
   logic         byte_done;
   logic [4:0]   next_idx;
   logic [7:0]   next_byte;

   assign accept     = send && !busy_q && clk_en;
   assign next_idx   = byte_idx_q + 5'd1;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

`ifdef PERF_TX_CHECKSUM_EN
   logic [7:0] csum;

   // Checksum over the frozen snapshot, so it always matches the sent bytes.
   always_comb begin
      csum = '0;
      for (int i = 0; i < PERF_TX_DATA_BYTES; i++) begin
         csum = csum ^ shadow_q[8*i +: 8];
      end
   end
`endif

   // Byte that follows the current one; index 1 is the MSB of cycle_count.
   always_comb begin
      next_byte = PERF_TX_HEADER;
      for (int i = 0; i < PERF_TX_DATA_BYTES; i++) begin
         if (next_idx == 5'(i + 1)) begin
            next_byte = shadow_q[8*(PERF_TX_DATA_BYTES-1-i) +: 8];
         end
      end
`ifdef PERF_TX_CHECKSUM_EN
      if (next_idx == 5'(PERF_TX_DATA_BYTES + 1)) begin
         next_byte = csum;
      end
`endif
   end

   // Frame sequencing: accept/snapshot, chain bytes, finish with frame_done.
   always_comb begin
      shadow_d     = shadow_q;
      byte_idx_d   = byte_idx_q;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
      byte_start   = 1'b0;
      byte_data    = PERF_TX_HEADER;
      if (accept) begin
         shadow_d   = {cycle_count, instr_count, load_stall_count, branch_stall_count};
         byte_idx_d = '0;
         busy_d     = 1'b1;
         byte_start = 1'b1;
      end else if (busy_q && byte_done) begin
         if (byte_idx_q == LAST_IDX) begin
            busy_d       = 1'b0;
            byte_idx_d   = '0;
            frame_done_d = 1'b1;
         end else begin
            byte_idx_d = next_idx;
            byte_start = 1'b1;
            byte_data  = next_byte;
         end
      end
   end

   // Sequencer registers with synchronous active-low reset; reset aborts a frame.
   always_ff @(posedge clk) begin
      if (!reset) begin
         shadow_q     <= '0;
         byte_idx_q   <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         shadow_q     <= shadow_d;
         byte_idx_q   <= byte_idx_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_tx_byte (
      .clk    (clk),
      .reset  (reset),
      .clk_en (clk_en),
      .start  (byte_start),
      .data   (byte_data),
      .tx     (tx),
      .done   (byte_done)
   );

endmodule

// File: tb/tb_perf_count_uart_tx.sv
// Scoreboard bench for perf_count_uart_tx at CLKS_PER_BIT = 4.
module tb_perf_count_uart_tx;
   localparam int CPB = 4;
`ifdef PERF_TX_CHECKSUM_EN
   localparam int NB = 18;
`else
   localparam int NB = 17;
`endif
   localparam int FLEN = NB * 10 * CPB;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        clk_en = 1'b1;
   logic        send = 1'b0;
   logic [31:0] cyc = '0, ins = '0, lds = '0, brs = '0;
   logic        tx, busy, frame_done;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] exp_q[$];
   int         len_q[$];

   perf_count_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk                (clk),
      .reset              (reset),
      .clk_en             (clk_en),
      .cycle_count        (cyc),
      .instr_count        (ins),
      .load_stall_count   (lds),
      .branch_stall_count (brs),
      .send               (send),
      .tx                 (tx),
      .busy               (busy),
      .frame_done         (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic push_frame(input logic [31:0] c, input logic [31:0] i,
                             input logic [31:0] l, input logic [31:0] b, input int extra);
      logic [127:0] s;
      logic [7:0]   x;
      logic [7:0]   v;
      s = {c, i, l, b};
      x = '0;
      exp_q.push_back(8'hA5);
      for (int k = 15; k >= 0; k--) begin
         v = s[8*k +: 8];
         exp_q.push_back(v);
         x = x ^ v;
      end
`ifdef PERF_TX_CHECKSUM_EN
      exp_q.push_back(x);
`endif
      len_q.push_back(FLEN + extra);
   endtask

   task automatic pulse_send();
      @(posedge clk); #1 send = 1'b1;
      @(posedge clk); #1 send = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int k;
      k = 0;
      while (k < budget) begin
         @(negedge clk);
         if (frame_done === 1'b1) begin
            n_tests++;
            return;
         end
         k++;
      end
      n_tests++;
      n_fail++;
      $display("FAIL %s: frame_done not seen within %0d cycles", name, budget);
   endtask

   // UART receiver: decodes bytes from tx and compares against the expected queue.
   initial begin : rx_mon
      logic [7:0] b;
      logic       stop;
      bit         ab;
      int         n;
      forever begin
         @(negedge clk);
         if (reset === 1'b1 && clk_en && tx === 1'b0) begin
            n = 0; ab = 0; b = '0; stop = 1'b0;
            while (n < 38) begin
               @(negedge clk);
               if (reset !== 1'b1) begin
                  ab = 1;
                  break;
               end
               if (clk_en) begin
                  n++;
                  if (n >= 6 && n <= 34 && ((n - 6) % 4) == 0) b[(n-6)/4] = tx;
                  if (n == 38) stop = tx;
               end
            end
            if (!ab) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL rx_unexpected_byte: got %h, expected no byte", b);
               end else begin
                  check("rx_byte", {24'h0, b}, {24'h0, exp_q.pop_front()});
                  check("rx_stop_bit", {31'h0, stop}, 32'h1);
               end
            end
         end
      end
   end

   // Frame monitor: busy duration per frame, frame_done coincident with busy fall.
   initial begin : busy_mon
      int cnt;
      bit inb;
      cnt = 0; inb = 0;
      forever begin
         @(negedge clk);
         if (reset !== 1'b1) begin
            cnt = 0; inb = 0;
         end else if (busy === 1'b1) begin
            if (!inb) cnt = 0;
            inb = 1;
            cnt++;
         end else if (inb) begin
            inb = 0;
            check("frame_done_at_end", {31'h0, frame_done}, 32'h1);
            if (len_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL frame_len_unexpected: got %0d cycles, expected no frame", cnt);
            end else begin
               check("frame_len", cnt, len_q.pop_front());
            end
         end else if (frame_done === 1'b1) begin
            n_fail++;
            $display("FAIL spurious_frame_done: got 1, expected 0");
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [7:0] s2_bytes [17];
      int seen;
      s2_bytes = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h08,
                   8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01};

      // 1: reset held with send high
      reset = 1'b0; send = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("rst_outputs", {29'h0, tx, busy, frame_done}, 32'h4);
      end
      @(posedge clk); #1 reset = 1'b1; send = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_no_frame", {31'h0, busy}, 32'h0);
      check("rst_tx_idle", {31'h0, tx}, 32'h1);

      // 2: basic frame, counters changed mid-frame
      cyc = 32'h10; ins = 32'h08; lds = 32'h02; brs = 32'h01;
      foreach (s2_bytes[k]) exp_q.push_back(s2_bytes[k]);
`ifdef PERF_TX_CHECKSUM_EN
      exp_q.push_back(8'h1B);
`endif
      len_q.push_back(FLEN);
      pulse_send();
      repeat (100) @(posedge clk);
      #1 cyc = 32'hFFFF_FFFF; ins = 32'h1234_5678; lds = 32'hAAAA_5555; brs = 32'h0F0F_F0F0;
      wait_done(FLEN + 50, "s2_done");

      // 3a: send during byte 3 is dropped
      cyc = 32'hDEAD_BEEF; ins = 32'h0123_4567; lds = 32'h89AB_CDEF; brs = 32'hCAFE_F00D;
      push_frame(cyc, ins, lds, brs, 0);
      pulse_send();
      repeat (130) @(posedge clk);
      #1 send = 1'b1;
      @(posedge clk); #1 send = 1'b0;
      wait_done(FLEN + 50, "s3a_done");
      repeat (20) @(negedge clk);
      check("s3a_no_second_frame", {31'h0, busy}, 32'h0);

      // 3b: send held through frame_done gives back-to-back frames
      cyc = 32'h8000_0001; ins = 32'h00FF_FF00; lds = 32'h5A5A_A5A5; brs = 32'h7654_3210;
      push_frame(cyc, ins, lds, brs, 0);
      push_frame(cyc, ins, lds, brs, 0);
      @(posedge clk); #1 send = 1'b1;
      wait_done(FLEN + 50, "s3b_first_done");
      @(posedge clk); #1 send = 1'b0;
      @(negedge clk);
      check("b2b_busy", {31'h0, busy}, 32'h1);
      check("b2b_tx_start", {31'h0, tx}, 32'h0);
      wait_done(FLEN + 50, "s3b_second_done");

      // 4: clk_en low for 10 cycles inside a data bit
      cyc = 32'h0000_00FF; ins = 32'h3C3C_C3C3; lds = 32'h0000_0000; brs = 32'hFFFF_0000;
      push_frame(cyc, ins, lds, brs, 10);
      pulse_send();
      repeat (50) @(posedge clk);
      #1 clk_en = 1'b0;
      repeat (10) @(posedge clk);
      #1 clk_en = 1'b1;
      wait_done(FLEN + 60, "s4_done");
      @(posedge clk); #1 clk_en = 1'b0; send = 1'b1;
      @(posedge clk); #1 clk_en = 1'b1; send = 1'b0;
      repeat (5) @(negedge clk);
      check("s4_send_while_disabled", {31'h0, busy}, 32'h0);

      // 5: reset during byte 5, then a clean frame
      cyc = 32'h1111_2222; ins = 32'h3333_4444; lds = 32'h5555_6666; brs = 32'h7777_8888;
      push_frame(cyc, ins, lds, brs, 0);
      pulse_send();
      repeat (210) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      check("s5_rst_outputs", {29'h0, tx, busy, frame_done}, 32'h4);
      exp_q.delete();
      len_q.delete();
      seen = 0;
      repeat (60) begin
         @(negedge clk);
         if (frame_done === 1'b1 || busy === 1'b1) seen++;
      end
      check("s5_no_done_after_abort", seen, 0);
      cyc = 32'h0BAD_F00D; ins = 32'h0000_0001; lds = 32'h8000_0000; brs = 32'h1357_9BDF;
      push_frame(cyc, ins, lds, brs, 0);
      pulse_send();
      wait_done(FLEN + 50, "s5_done");

      repeat (5) @(negedge clk);
      check("exp_q_drained", exp_q.size(), 0);
      check("len_q_drained", len_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
